// File: rtl/sif_bridge.sv
// XA-to-WA write bridge: local register file with registered reads, plus an
// in-order forwarding FIFO toward the WA sink with sticky overflow reporting.
module sif_bridge #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned REG_CNT    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              xa_wr_s,
  input  logic              xa_rd_s,
  input  logic [ADDR_W-1:0] xa_addr,
  input  logic [DATA_W-1:0] xa_data_wr,
  output logic              xa_wr_rdy,
  output logic [DATA_W-1:0] xa_data_rd,
  output logic              xa_rd_vld,
  output logic              wa_wr_s,
  output logic [ADDR_W-1:0] wa_addr,
  output logic [DATA_W-1:0] wa_data_wr,
  input  logic              wa_rdy,
  output logic              ovf_err
);

  localparam int unsigned IdxW   = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;
  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = ADDR_W + DATA_W;

  logic [DATA_W-1:0] regs_q [REG_CNT];
  logic [EntryW-1:0] mem_q  [FIFO_DEPTH];

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_vld_q;

  logic              in_range;
  logic [IdxW-1:0]   idx;
  logic              push, pop;
  logic [EntryW-1:0] head;

  always_comb begin
    in_range  = (xa_addr >> IdxW) == '0;
    idx       = xa_addr[IdxW-1:0];
    xa_wr_rdy = cnt_q != CntW'(FIFO_DEPTH);
    wa_wr_s   = cnt_q != '0;
    push      = xa_wr_s && xa_wr_rdy;
    pop       = wa_wr_s && wa_rdy;
    head      = mem_q[rd_ptr_q];
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    rd_data_d = rd_data_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) cnt_d = cnt_q + CntW'(1);
    if (pop && !push) cnt_d = cnt_q - CntW'(1);
    if (xa_wr_s && !xa_wr_rdy) ovf_d = 1'b1;
    // Read samples the register file before this cycle's write lands.
    if (xa_rd_s) rd_data_d = in_range ? regs_q[idx] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= xa_rd_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_CNT); i++) regs_q[i] <= '0;
    end else if (push && in_range) begin
      regs_q[idx] <= xa_data_wr;
    end
  end

  // Storage is cleared so the WA head reads zero while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {xa_addr, xa_data_wr};
    end
  end

  assign wa_addr    = head[EntryW-1:DATA_W];
  assign wa_data_wr = head[DATA_W-1:0];
  assign xa_data_rd = rd_data_q;
  assign xa_rd_vld  = rd_vld_q;
  assign ovf_err    = ovf_q;

endmodule
